// File: rtl/mio_bus_responder.sv
// mio_bus_responder
//
// Responder end of the CPU data-memory / MIO interface. The CPU issues a
// request strobe with address, lane-positioned store data and byte-lane
// write enables; this block answers from a byte-lane-writable word RAM or
// from a small MMIO register window, then raises a one-cycle ready pulse
// after a fixed number of wait states.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous, active-high reset
//   CPU_MIO    request strobe, held by the CPU until MIO_ready
//   mem_w      1 = store, 0 = load
//   wea[3:0]   byte-lane write enables (bit i covers Data_in[8i+7:8i])
//   Addr_in    byte address (bits [1:0] ignored)
//   Data_in    lane-positioned store data
//   Data_out   registered read word (read-before-write for stores too)
//   MIO_ready  one-cycle completion pulse
//   sw_in      board switches
//   led_out    LED register
//
// MMIO window (Addr_in[31:28] == MMIO_NIBBLE), register picked by Addr_in[3:2]:
//   0 LED (lanes 0/1 writable), 1 switches (RO), 2 free-running cycle
//   counter (RO), 3 unmapped (reads 0).

module mio_bus_responder #(
    parameter int         ADDR_WORDS_LOG2 = 10,
    parameter int         WAIT_CYCLES     = 1,
    parameter logic [3:0] MMIO_NIBBLE     = 4'hF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        CPU_MIO,
    input  logic        mem_w,
    input  logic [3:0]  wea,
    input  logic [31:0] Addr_in,
    input  logic [31:0] Data_in,
    output logic [31:0] Data_out,
    output logic        MIO_ready,
    input  logic [15:0] sw_in,
    output logic [15:0] led_out
);

    localparam int         DEPTH     = 1 << ADDR_WORDS_LOG2;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t state_reg, state_next;
    logic [3:0] cnt_reg, cnt_next;

    // Request fields latched when the request is accepted in IDLE.
    logic [ADDR_WORDS_LOG2-1:0] idx_reg;
    logic                       mmio_reg;
    logic [1:0]                 off_reg;
    logic [31:0]                data_reg;
    logic [3:0]                 wea_reg;
    logic                       mem_w_reg;

    logic [31:0] cyc_reg;
    logic [15:0] led_reg;
    logic [31:0] mmio_rd_reg;
    logic        sel_mmio_reg;
    logic [31:0] ram_rd_word;

    logic                       capture;
    logic                       enter_done;
    logic                       commit;
    logic                       ram_commit;
    logic [ADDR_WORDS_LOG2-1:0] req_idx;
    logic                       req_mmio;
    logic [1:0]                 req_off;
    logic [ADDR_WORDS_LOG2-1:0] rd_idx;
    logic                       rd_mmio;
    logic [1:0]                 rd_off;
    logic [31:0]                mmio_rd_val;

    // Address bits that never take part in decode (word aliasing).
    logic unused_addr_bits;
    assign unused_addr_bits = ^{Addr_in[27:ADDR_WORDS_LOG2+2], Addr_in[1:0]};

    assign req_idx  = Addr_in[ADDR_WORDS_LOG2+1:2];
    assign req_mmio = (Addr_in[31:28] == MMIO_NIBBLE);
    assign req_off  = Addr_in[3:2];

    assign capture    = (state_reg == S_IDLE) && CPU_MIO;
    assign enter_done = (state_next == S_DONE);
    // A reset on the edge leaving DONE aborts the request, so the commit is
    // gated by reset as well as by the store flag.
    assign commit     = (state_reg == S_DONE) && mem_w_reg && !reset;
    assign ram_commit = commit && !mmio_reg;

    // With zero wait states DONE is entered straight from IDLE, before the
    // request fields are latched, so the read uses the live address then.
    assign rd_idx  = capture ? req_idx  : idx_reg;
    assign rd_mmio = capture ? req_mmio : mmio_reg;
    assign rd_off  = capture ? req_off  : off_reg;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            S_IDLE: begin
                if (CPU_MIO) begin
                    cnt_next   = WAIT_INIT;
                    state_next = (WAIT_INIT == 4'd0) ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_reg == 4'd1) begin
                    state_next = S_DONE;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        mmio_rd_val = '0;
        case (rd_off)
            2'd0:    mmio_rd_val = {16'b0, led_reg};
            2'd1:    mmio_rd_val = {16'b0, sw_in};
            2'd2:    mmio_rd_val = cyc_reg;
            default: mmio_rd_val = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= S_IDLE;
            cnt_reg      <= '0;
            idx_reg      <= '0;
            mmio_reg     <= 1'b0;
            off_reg      <= '0;
            data_reg     <= '0;
            wea_reg      <= '0;
            mem_w_reg    <= 1'b0;
            cyc_reg      <= '0;
            led_reg      <= '0;
            mmio_rd_reg  <= '0;
            // Selecting the (cleared) MMIO read register makes Data_out read
            // zero after reset without needing a reset on the RAM output.
            sel_mmio_reg <= 1'b1;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            cyc_reg   <= cyc_reg + 32'd1;
            if (capture) begin
                idx_reg   <= req_idx;
                mmio_reg  <= req_mmio;
                off_reg   <= req_off;
                data_reg  <= Data_in;
                wea_reg   <= wea;
                mem_w_reg <= mem_w;
            end
            if (enter_done) begin
                sel_mmio_reg <= rd_mmio;
                if (rd_mmio) begin
                    mmio_rd_reg <= mmio_rd_val;
                end
            end
            if (commit && mmio_reg && (off_reg == 2'd0)) begin
                if (wea_reg[0]) led_reg[7:0]  <= data_reg[7:0];
                if (wea_reg[1]) led_reg[15:8] <= data_reg[15:8];
            end
        end
    end

    // One byte-wide RAM per lane keeps each lane's write port independent.
    // The read is enabled only on the edge entering DONE, which is always a
    // different edge from the commit (leaving DONE), giving read-before-write.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];
            logic [7:0] rd_byte_reg;

            always_ff @(posedge clk) begin
                if (ram_commit && wea_reg[gi]) begin
                    lane_mem[idx_reg] <= data_reg[8*gi +: 8];
                end
                if (enter_done) begin
                    rd_byte_reg <= lane_mem[rd_idx];
                end
            end

            assign ram_rd_word[8*gi +: 8] = rd_byte_reg;
        end
    endgenerate

    assign Data_out  = sel_mmio_reg ? mmio_rd_reg : ram_rd_word;
    assign MIO_ready = (state_reg == S_DONE);
    assign led_out   = led_reg;

endmodule

// File: tb/tb_mio_bus_responder.sv
// Testbench for mio_bus_responder: a WAIT_CYCLES=1 instance carries the
// table of load/store vectors and the reset-abort sequences; a second
// WAIT_CYCLES=3 instance checks the continuous-request pulse pattern.

module tb_mio_bus_responder;

    localparam int W1 = 1;
    localparam int W3 = 3;

    logic        clk;
    logic        reset;
    logic        cpu_mio;
    logic        cpu_mio3;
    logic        mem_w;
    logic [3:0]  wea;
    logic [31:0] addr;
    logic [31:0] data_in;
    logic [31:0] dout;
    logic [31:0] dout3;
    logic        ready;
    logic        ready3;
    logic [15:0] sw;
    logic [15:0] led;
    logic [15:0] led3;

    int n_pass;
    int n_total;

    mio_bus_responder #(
        .ADDR_WORDS_LOG2(10),
        .WAIT_CYCLES    (W1),
        .MMIO_NIBBLE    (4'hF)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .CPU_MIO  (cpu_mio),
        .mem_w    (mem_w),
        .wea      (wea),
        .Addr_in  (addr),
        .Data_in  (data_in),
        .Data_out (dout),
        .MIO_ready(ready),
        .sw_in    (sw),
        .led_out  (led)
    );

    mio_bus_responder #(
        .ADDR_WORDS_LOG2(10),
        .WAIT_CYCLES    (W3),
        .MMIO_NIBBLE    (4'hF)
    ) dut3 (
        .clk      (clk),
        .reset    (reset),
        .CPU_MIO  (cpu_mio3),
        .mem_w    (mem_w),
        .wea      (wea),
        .Addr_in  (addr),
        .Data_in  (data_in),
        .Data_out (dout3),
        .MIO_ready(ready3),
        .sw_in    (sw),
        .led_out  (led3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        mw;
        logic [3:0]  we;
        logic [31:0] a;
        logic [31:0] d;
        logic        chk;
        logic [31:0] exp_data;
        logic [15:0] exp_led;
    } vec_t;

    typedef struct {
        string       name;
        logic        chk;
        logic [31:0] exp_data;
    } sb_t;

    vec_t vq[$];
    sb_t  sb_q[$];

    task automatic add_vec(input string n, input logic mw, input logic [3:0] we,
                           input logic [31:0] a, input logic [31:0] d, input logic chk,
                           input logic [31:0] e, input logic [15:0] l);
        vec_t v;
        v.name = n; v.mw = mw; v.we = we; v.a = a; v.d = d;
        v.chk = chk; v.exp_data = e; v.exp_led = l;
        vq.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    endtask

    // Drives one request at the current negedge (state IDLE), waits for the
    // ready pulse, checks latency/data via the scoreboard, then checks that
    // the pulse is one cycle wide. Returns at the following negedge (IDLE).
    task automatic do_req(input string name, input logic mw, input logic [3:0] we,
                          input logic [31:0] a, input logic [31:0] d, input logic chk,
                          input logic [31:0] e, output logic [31:0] got);
        sb_t s;
        int  k;
        logic seen;
        s.name = name; s.chk = chk; s.exp_data = e;
        sb_q.push_back(s);
        cpu_mio = 1'b1; mem_w = mw; wea = we; addr = a; data_in = d;
        k = 0;
        seen = 1'b0;
        while (!seen && k < 20) begin
            @(negedge clk);
            k++;
            seen = ready;
        end
        cpu_mio = 1'b0;
        got = dout;
        if (!seen) begin
            n_total++;
            $display("FAIL %s_timeout: no ready within 20 cycles", name);
        end else begin
            check({name, "_lat"}, 32'(k), 32'(W1 + 1));
        end
        if (sb_q.size() > 0) begin
            s = sb_q.pop_front();
            if (s.chk) check(s.name, dout, s.exp_data);
        end
        $display("txn %s mw=%b we=%b addr=%08h wdata=%08h rdata=%08h lat=%0d",
                 name, mw, we, a, d, dout, k);
        @(negedge clk);
        check({name, "_pulse"}, {31'b0, ready}, 32'h0);
    endtask

    logic [31:0] got;
    logic [31:0] cnt_a;
    logic [31:0] cnt_b;
    logic [31:0] seen_cnt;
    logic [31:0] cap [3];
    int          pulses;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        n_pass = 0; n_total = 0;
        reset = 1'b1; cpu_mio = 1'b0; cpu_mio3 = 1'b0;
        mem_w = 1'b0; wea = 4'h0; addr = 32'h0; data_in = 32'h0;
        sw = 16'h5A5A;

        // name          mw    we       addr          data          chk   exp data      exp led
        add_vec("st40",       1'b1, 4'b1111, 32'h00000040, 32'hDEADBEEF, 1'b0, 32'h00000000, 16'h0000);
        add_vec("ld40",       1'b0, 4'b0000, 32'h00000040, 32'h00000000, 1'b1, 32'hDEADBEEF, 16'h0000);
        add_vec("st42_lane2", 1'b1, 4'b0100, 32'h00000042, 32'h00AA0000, 1'b1, 32'hDEADBEEF, 16'h0000);
        add_vec("ld40_b",     1'b0, 4'b0000, 32'h00000040, 32'h00000000, 1'b1, 32'hDEAABEEF, 16'h0000);
        add_vec("ld_wea_set", 1'b0, 4'b1111, 32'h00000040, 32'h11111111, 1'b1, 32'hDEAABEEF, 16'h0000);
        add_vec("ld40_c",     1'b0, 4'b0000, 32'h00000040, 32'h00000000, 1'b1, 32'hDEAABEEF, 16'h0000);
        add_vec("st_led",     1'b1, 4'b0011, 32'hF0000000, 32'h1234ABCD, 1'b1, 32'h00000000, 16'hABCD);
        add_vec("ld_led",     1'b0, 4'b0000, 32'hF0000000, 32'h00000000, 1'b1, 32'h0000ABCD, 16'hABCD);
        add_vec("ld_sw",      1'b0, 4'b0000, 32'hF0000004, 32'h00000000, 1'b1, 32'h00005A5A, 16'hABCD);
        add_vec("ld_unmap",   1'b0, 4'b0000, 32'hF000000C, 32'h00000000, 1'b1, 32'h00000000, 16'hABCD);
        add_vec("st_unmap",   1'b1, 4'b1111, 32'hF000000C, 32'hFFFFFFFF, 1'b1, 32'h00000000, 16'hABCD);
        add_vec("ld_unmap2",  1'b0, 4'b0000, 32'hF000000C, 32'h00000000, 1'b1, 32'h00000000, 16'hABCD);
        add_vec("st_sw",      1'b1, 4'b1111, 32'hF0000004, 32'hFFFFFFFF, 1'b1, 32'h00005A5A, 16'hABCD);
        add_vec("ld_sw2",     1'b0, 4'b0000, 32'hF0000004, 32'h00000000, 1'b1, 32'h00005A5A, 16'hABCD);
        add_vec("st_led_hi",  1'b1, 4'b1100, 32'hF0000000, 32'hFFFF0000, 1'b1, 32'h0000ABCD, 16'hABCD);
        add_vec("st_led_lo",  1'b1, 4'b0001, 32'hF0000000, 32'h00000077, 1'b1, 32'h0000ABCD, 16'hAB77);
        add_vec("ld_led2",    1'b0, 4'b0000, 32'hF0000000, 32'h00000000, 1'b1, 32'h0000AB77, 16'hAB77);
        add_vec("st_alias",   1'b1, 4'b1111, 32'h00001040, 32'hCAFEF00D, 1'b1, 32'hDEAABEEF, 16'hAB77);
        add_vec("ld_alias",   1'b0, 4'b0000, 32'h00000040, 32'h00000000, 1'b1, 32'hCAFEF00D, 16'hAB77);
        add_vec("st44",       1'b1, 4'b1111, 32'h00000044, 32'h55667788, 1'b0, 32'h00000000, 16'hAB77);
        add_vec("st44_nowea", 1'b1, 4'b0000, 32'h00000044, 32'h12345678, 1'b1, 32'h55667788, 16'hAB77);
        add_vec("st46_half",  1'b1, 4'b1100, 32'h00000046, 32'hBEEF0000, 1'b1, 32'h55667788, 16'hAB77);
        add_vec("ld44",       1'b0, 4'b0000, 32'h00000044, 32'h00000000, 1'b1, 32'hBEEF7788, 16'hAB77);
        add_vec("ld40_d",     1'b0, 4'b0000, 32'h00000040, 32'h00000000, 1'b1, 32'hCAFEF00D, 16'hAB77);
        add_vec("ld_e_nib",   1'b0, 4'b0000, 32'hE0000040, 32'h00000000, 1'b1, 32'hCAFEF00D, 16'hAB77);

        repeat (3) @(negedge clk);
        check("rst_dout",   dout,            32'h0);
        check("rst_ready",  {31'b0, ready},  32'h0);
        check("rst_led",    {16'b0, led},    32'h0);
        check("rst_dout3",  dout3,           32'h0);
        check("rst_ready3", {31'b0, ready3}, 32'h0);

        // Counter is 0 in the first cycle after reset; the read samples it
        // on the DONE-entry edge two edges later, when it holds 1.
        reset = 1'b0;
        do_req("ld_cnt_rst", 1'b0, 4'h0, 32'hF0000008, 32'h0, 1'b1, 32'd1, got);

        foreach (vq[i]) begin
            do_req(vq[i].name, vq[i].mw, vq[i].we, vq[i].a, vq[i].d,
                   vq[i].chk, vq[i].exp_data, got);
            check({vq[i].name, "_led"}, {16'b0, led}, {16'b0, vq[i].exp_led});
        end

        // Back-to-back counter reads are W1+2 cycles apart.
        do_req("ld_cnt_a", 1'b0, 4'h0, 32'hF0000008, 32'h0, 1'b0, 32'h0, cnt_a);
        do_req("ld_cnt_b", 1'b0, 4'h0, 32'hF0000008, 32'h0, 1'b0, 32'h0, cnt_b);
        check("cnt_b2b_diff", cnt_b - cnt_a, 32'(W1 + 2));

        // Reset during WAIT aborts a store.
        do_req("st80",    1'b1, 4'hF, 32'h00000080, 32'h13572468, 1'b0, 32'h0, got);
        do_req("ld40_e",  1'b0, 4'h0, 32'h00000040, 32'h0, 1'b1, 32'hCAFEF00D, got);
        cpu_mio = 1'b1; mem_w = 1'b1; wea = 4'hF; addr = 32'h80; data_in = 32'h0BADF00D;
        @(negedge clk);
        reset = 1'b1; cpu_mio = 1'b0;
        seen_cnt = 32'h0;
        @(negedge clk);
        seen_cnt += {31'b0, ready};
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            seen_cnt += {31'b0, ready};
        end
        $display("txn rst_in_wait ready_seen=%0d dout=%08h led=%04h", seen_cnt, dout, led);
        check("rstwait_noready", seen_cnt,      32'h0);
        check("rstwait_dout",    dout,          32'h0);
        check("rstwait_led",     {16'b0, led},  32'h0);
        do_req("ld80_after_wait", 1'b0, 4'h0, 32'h00000080, 32'h0, 1'b1, 32'h13572468, got);

        // Reset during DONE aborts the commit.
        do_req("ld40_f",  1'b0, 4'h0, 32'h00000040, 32'h0, 1'b1, 32'hCAFEF00D, got);
        cpu_mio = 1'b1; mem_w = 1'b1; wea = 4'hF; addr = 32'h80; data_in = 32'h0BADF00D;
        @(negedge clk);
        @(negedge clk);
        check("rstdone_ready_hi", {31'b0, ready}, 32'h1);
        reset = 1'b1; cpu_mio = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        $display("txn rst_in_done dout=%08h ready=%b", dout, ready);
        check("rstdone_dout",  dout,            32'h0);
        check("rstdone_ready", {31'b0, ready},  32'h0);
        do_req("ld80_after_done", 1'b0, 4'h0, 32'h00000080, 32'h0, 1'b1, 32'h13572468, got);

        // WAIT_CYCLES=3 instance with the strobe held high from cycle 0.
        addr = 32'hF0000008; mem_w = 1'b0; wea = 4'h0;
        cap[0] = 32'h0; cap[1] = 32'h0; cap[2] = 32'h0;
        pulses = 0;
        cpu_mio3 = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            check($sformatf("w3_ready_c%0d", k), {31'b0, ready3},
                  {31'b0, (k == 4 || k == 9 || k == 14)});
            if (ready3 && pulses < 3) begin
                cap[pulses] = dout3;
                $display("txn w3_pulse cycle=%0d cnt=%08h", k, dout3);
                pulses++;
            end
            if (k == 14) cpu_mio3 = 1'b0;
        end
        check("w3_cnt_diff1", cap[1] - cap[0], 32'(W3 + 2));
        check("w3_cnt_diff2", cap[2] - cap[1], 32'(W3 + 2));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
